// File: rtl/avg_unpool_pkg.sv
// avg_unpool_pkg: FP16 field layout, stream FSM states and frame sizing shared by
// the average-unpool stream and its FP16 scale unit.
package avg_unpool_pkg;

   localparam int unsigned EXP_W      = 5;
   localparam int unsigned MAN_W      = 10;
   localparam logic [4:0]  EXP_INF    = 5'd31;

   localparam int unsigned DEF_IN_DIM = 14;
   localparam int unsigned OUT_BEATS  = 4 * DEF_IN_DIM * DEF_IN_DIM;

   typedef enum logic {
      ROW_A,
      ROW_B
   } state_t;

endpackage

// File: rtl/fp16_div4.sv
// fp16_div4: combinational FP16 multiply by 1/4. Subnormal results truncate unless
// AVG_UNPOOL_RNE_EN is defined, which selects round-to-nearest-even.
module fp16_div4
   import avg_unpool_pkg::*;
(
   input  logic [15:0] a_i,
   output logic [15:0] y_o
);

   localparam int unsigned W = 1 + EXP_W + MAN_W;

   logic             sign;
   logic [EXP_W-1:0] exp_f;
   logic [MAN_W-1:0] man_f;
   logic [MAN_W-1:0] sub_man;
   logic [W-2:0]     mag;

   always_comb begin
      sign  = a_i[W-1];
      exp_f = a_i[W-2:MAN_W];
      man_f = a_i[MAN_W-1:0];

      sub_man = '0;
      if (exp_f == EXP_W'(2)) begin
         sub_man = MAN_W'({1'b1, man_f} >> 1);
      end else if (exp_f == EXP_W'(1)) begin
         sub_man = MAN_W'({1'b1, man_f} >> 2);
      end else begin
         sub_man = man_f >> 2;
      end
      mag = {{EXP_W{1'b0}}, sub_man};

`ifdef AVG_UNPOOL_RNE_EN
      begin : rne
         logic guard;
         logic sticky;
         guard  = 1'b0;
         sticky = 1'b0;
         if (exp_f == EXP_W'(2)) begin
            guard = man_f[0];
         end else if (exp_f == EXP_W'(1)) begin
            guard  = man_f[1];
            sticky = man_f[0];
         end else begin
            guard  = man_f[1];
            sticky = man_f[0];
         end
         // a carry out of the mantissa lands in the exponent field as the correct normal code
         if (guard && (sticky || sub_man[0])) begin
            mag = mag + (W-1)'(1);
         end
      end
`endif

      y_o = a_i;
      if (exp_f == EXP_INF) begin
         y_o = a_i;
      end else if (exp_f >= EXP_W'(3)) begin
         y_o = {sign, exp_f - EXP_W'(2), man_f};
      end else begin
         y_o = {sign, mag};
      end
   end

endmodule

// File: rtl/avg_unpool_stream.sv
// avg_unpool_stream: 2x2 average-unpool distributor, one FP16 word in, its v/4 written
// to a 2x2 footprint out. Build option AVG_UNPOOL_RNE_EN selects subnormal rounding.
module avg_unpool_stream
   import avg_unpool_pkg::*;
#(
   parameter int unsigned IN_DIM = DEF_IN_DIM,
   parameter int unsigned DATA_W = 16
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              frame_done
);

   localparam int unsigned COL_W       = $clog2(IN_DIM + 1);
   localparam int unsigned IDX_W       = $clog2(IN_DIM);
   localparam int unsigned ROW_W       = $clog2(IN_DIM);
   localparam int unsigned FRAME_BEATS = OUT_BEATS / (DEF_IN_DIM * DEF_IN_DIM) * IN_DIM * IN_DIM;
   localparam int unsigned BEAT_W      = $clog2(FRAME_BEATS);

   state_t              state_q, state_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic                phase_q, phase_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [DATA_W-1:0]   hold_q, hold_d;
   logic                hold_valid_q, hold_valid_d;
   logic                frame_done_q, frame_done_d;
   logic [DATA_W-1:0]   line_buf [IN_DIM];

   logic [DATA_W-1:0]   scaled;
   logic                col_full;
   logic                fire_out;
   logic                accept;

   fp16_div4 u_div4 (
      .a_i (in_data),
      .y_o (scaled)
   );

   // col_q counts accepted words in ROW_A and replayed words in ROW_B
   assign col_full  = (col_q == COL_W'(IN_DIM));
   assign out_valid = !reset && ((state_q == ROW_B) || hold_valid_q);
   assign in_ready  = !reset && (state_q == ROW_A) && !col_full
                      && (!hold_valid_q || (phase_q && out_ready));
   assign fire_out  = out_valid && out_ready;
   assign accept    = in_valid && in_ready;

   assign out_data   = (state_q == ROW_A) ? hold_q : line_buf[col_q[IDX_W-1:0]];
   assign out_last   = out_valid && (beat_q == BEAT_W'(FRAME_BEATS - 1));
   assign frame_done = frame_done_q;

   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      col_d        = col_q;
      phase_d      = phase_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      frame_done_d = 1'b0;
      beat_d       = beat_q;

      if (fire_out) begin
         beat_d = out_last ? '0 : beat_q + 1'b1;
      end

      unique case (state_q)
         ROW_A: begin
            if (fire_out) begin
               phase_d = ~phase_q;
               if (phase_q) begin
                  hold_valid_d = 1'b0;
                  if (col_full) begin
                     state_d = ROW_B;
                     col_d   = '0;
                  end
               end
            end
            // a same-cycle accept refills the hold register as the second beat drains
            if (accept) begin
               hold_d       = scaled;
               hold_valid_d = 1'b1;
               col_d        = col_q + 1'b1;
            end
         end
         ROW_B: begin
            if (fire_out) begin
               phase_d = ~phase_q;
               if (phase_q) begin
                  if (col_q == COL_W'(IN_DIM - 1)) begin
                     col_d   = '0;
                     state_d = ROW_A;
                     if (row_q == ROW_W'(IN_DIM - 1)) begin
                        row_d        = '0;
                        frame_done_d = 1'b1;
                     end else begin
                        row_d = row_q + 1'b1;
                     end
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end
            end
         end
         default: state_d = ROW_A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ROW_A;
         row_q        <= '0;
         col_q        <= '0;
         phase_q      <= 1'b0;
         beat_q       <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         col_q        <= col_d;
         phase_q      <= phase_d;
         beat_q       <= beat_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         line_buf[col_q[IDX_W-1:0]] <= scaled;
      end
   end

endmodule

// File: tb/tb_avg_unpool_stream.sv
// tb_avg_unpool_stream: table-driven and scoreboard bench for the average-unpool stream.
module tb_avg_unpool_stream;

   typedef struct {
      logic [15:0] din;
      logic [15:0] dout;
   } vec_t;

   typedef struct {
      logic [15:0] d;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_last;
   logic        frame_done;

   avg_unpool_stream #(.IN_DIM(14), .DATA_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .frame_done (frame_done)
   );

   initial forever #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned cyc = 0;

   logic [15:0] pix     [196];
   logic [15:0] exp_pix [196];
   vec_t        tbl     [16];
   exp_t        sb      [$];

   bit          rand_ready = 1'b0;
   bit          span_mode = 1'b0;
   bit          b2b_mode = 1'b0;
   bit          b2b_arm = 1'b0;
   int unsigned fd_count = 0;

   always @(posedge clk) cyc <= cyc + 1;

   initial forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [15:0] ref_div4(input logic [15:0] v);
      logic [4:0]  e;
      int unsigned mag;
      int unsigned q;
      e = v[14:10];
      if (e == 5'd31) return v;
      if (e >= 5'd3) return v - 16'h0800;
      mag = (e == 5'd0) ? int'(v[9:0]) : ((1024 + int'(v[9:0])) << (e - 1));
      q = mag >> 2;
`ifdef AVG_UNPOOL_RNE_EN
      begin
         int unsigned r;
         r = mag & 3;
         if (r > 2 || (r == 2 && (q & 1) == 1)) q++;
      end
`endif
      return {v[15], 15'(q)};
   endfunction

   // monitor and scoreboard, sampled on the falling edge
   int unsigned acc_idx = 0;
   int unsigned beat_cnt = 0;
   int unsigned last_cycle = 0;
   int unsigned first_acc_cycle = 0;
   bit          stall_prev = 1'b0;
   bit          fd_exp = 1'b0;
   bit          lat_chk = 1'b0;
   logic [15:0] stall_data;
   logic [15:0] rowexp [14];

   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
         acc_idx    = 0;
         beat_cnt   = 0;
         stall_prev = 1'b0;
         fd_exp     = 1'b0;
         lat_chk    = 1'b0;
         b2b_arm    = 1'b0;
         chk(!in_ready && !out_valid && !out_last, "reset_outputs",
             {in_ready, out_valid, out_last}, 0);
      end else begin
         if (lat_chk) chk(out_valid == 1'b1, "first_beat_latency", out_valid, 1);
         if (stall_prev) chk(out_valid && out_data == stall_data, "stall_hold",
                             {out_valid, out_data}, {1'b1, stall_data});
         if (fd_exp || frame_done) begin
            chk(frame_done == fd_exp, "frame_done", frame_done, fd_exp);
            if (frame_done) fd_count++;
         end
         fd_exp = 1'b0;

         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk(1'b0, "unexpected_beat", out_data, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               beat_cnt++;
               chk(out_data == e.d && out_last == e.last, "beat",
                   {out_last, out_data}, {e.last, e.d});
               if (e.last) begin
                  chk(beat_cnt == 784, "frame_beats", beat_cnt, 784);
                  if (span_mode) chk(cyc - first_acc_cycle == 797, "frame_span",
                                     cyc - first_acc_cycle, 797);
                  beat_cnt   = 0;
                  fd_exp     = 1'b1;
                  last_cycle = cyc;
                  b2b_arm    = b2b_mode;
               end
            end
         end
         stall_prev = out_valid && !out_ready;
         stall_data = out_data;

         lat_chk = in_valid && in_ready;
         if (in_valid && in_ready) begin
            int unsigned r, c;
            logic [15:0] ev;
            r  = acc_idx / 14;
            c  = acc_idx % 14;
            ev = exp_pix[acc_idx];
            if (acc_idx == 0) begin
               first_acc_cycle = cyc;
               if (b2b_arm) begin
                  chk(cyc == last_cycle + 1, "b2b_start", cyc, last_cycle + 1);
                  b2b_arm = 1'b0;
               end
            end
            rowexp[c] = ev;
            sb.push_back('{ev, 1'b0});
            sb.push_back('{ev, 1'b0});
            if (c == 13) begin
               for (int k = 0; k < 14; k++) begin
                  sb.push_back('{rowexp[k], 1'b0});
                  sb.push_back('{rowexp[k], (r == 13 && k == 13)});
               end
            end
            acc_idx = (acc_idx == 195) ? 0 : acc_idx + 1;
         end
      end
   end

   task automatic send_frame(input int unsigned n, input bit gaps, input bit drop);
      for (int unsigned i = 0; i < n; i++) begin
         int unsigned wait_cyc;
         bit          done;
         wait_cyc = 0;
         done     = 1'b0;
         if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
               in_valid = 1'b0;
               @(posedge clk);
               #1;
            end
         end
         in_data  = pix[i];
         in_valid = 1'b1;
         while (!done) begin
            @(negedge clk);
            if (in_ready) begin
               done = 1'b1;
            end else if (++wait_cyc > 2000) begin
               chk(1'b0, "accept_timeout", i, n);
               done = 1'b1;
            end
            @(posedge clk);
            #1;
         end
      end
      if (drop) in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int unsigned n;
      n = 0;
      while ((sb.size() != 0 || out_valid) && n < 6000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(n < 6000, "drain_timeout", n, 6000);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, %0d cycles", cyc);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned fd0;

      tbl[0]  = '{16'h0800, 16'h0200};
      tbl[1]  = '{16'h7C00, 16'h7C00};
      tbl[2]  = '{16'hFE00, 16'hFE00};
      tbl[3]  = '{16'h4400, 16'h3C00};
      tbl[4]  = '{16'h4000, 16'h3800};
      tbl[5]  = '{16'h4800, 16'h4000};
      tbl[6]  = '{16'h0C01, 16'h0401};
      tbl[7]  = '{16'h0401, 16'h0100};
      tbl[8]  = '{16'hFC01, 16'hFC01};
      tbl[9]  = '{16'h0000, 16'h0000};
      tbl[10] = '{16'h8000, 16'h8000};
      tbl[11] = '{16'h0002, 16'h0000};
`ifdef AVG_UNPOOL_RNE_EN
      tbl[12] = '{16'h8003, 16'h8001};
      tbl[13] = '{16'h0003, 16'h0001};
      tbl[14] = '{16'h0BFF, 16'h0400};
      tbl[15] = '{16'h0406, 16'h0102};
`else
      tbl[12] = '{16'h8003, 16'h8000};
      tbl[13] = '{16'h0003, 16'h0000};
      tbl[14] = '{16'h0BFF, 16'h03FF};
      tbl[15] = '{16'h0406, 16'h0101};
`endif

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // uniform 4.0 frame, full throughput
      for (int i = 0; i < 196; i++) begin
         pix[i]     = 16'h4400;
         exp_pix[i] = 16'h3C00;
      end
      fd0       = fd_count;
      span_mode = 1'b1;
      send_frame(196, 1'b0, 1'b1);
      wait_drain();
      span_mode = 1'b0;
      chk(fd_count == fd0 + 1, "uniform_frame_done", fd_count - fd0, 1);

      // special values from the vector table
      for (int i = 0; i < 196; i++) begin
         pix[i]     = tbl[i % 16].din;
         exp_pix[i] = tbl[i % 16].dout;
      end
      send_frame(196, 1'b0, 1'b1);
      wait_drain();

      // alternating 2.0 / 8.0 per column
      for (int i = 0; i < 196; i++) begin
         pix[i]     = ((i % 14) % 2 == 0) ? 16'h4000 : 16'h4800;
         exp_pix[i] = ((i % 14) % 2 == 0) ? 16'h3800 : 16'h4000;
      end
      send_frame(196, 1'b0, 1'b1);
      wait_drain();

      // random words, stall-free then with random stalls and input gaps
      for (int i = 0; i < 196; i++) begin
         pix[i]     = 16'($urandom);
         exp_pix[i] = ref_div4(pix[i]);
      end
      send_frame(196, 1'b0, 1'b1);
      wait_drain();
      rand_ready = 1'b1;
      send_frame(196, 1'b1, 1'b1);
      wait_drain();

      // reset after 37 words, then a fresh frame
      send_frame(37, 1'b1, 1'b1);
      rand_ready = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 196; i++) begin
         pix[i]     = 16'($urandom);
         exp_pix[i] = ref_div4(pix[i]);
      end
      pix[0]     = 16'h3C00;
      exp_pix[0] = 16'h3400;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      fd0 = fd_count;
      send_frame(196, 1'b0, 1'b1);
      wait_drain();
      chk(fd_count == fd0 + 1, "post_reset_frame_done", fd_count - fd0, 1);

      // two frames back to back
      fd0      = fd_count;
      b2b_mode = 1'b1;
      send_frame(196, 1'b0, 1'b0);
      send_frame(196, 1'b0, 1'b1);
      wait_drain();
      b2b_mode = 1'b0;
      chk(fd_count == fd0 + 2, "b2b_frame_done", fd_count - fd0, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
